// File: rtl/mux2_stream_arbiter_pkg.sv
// Shared definitions for the two-input stream arbiter: source encodings and
// lock-FSM state encodings.
package mux2_stream_arbiter_pkg;

   localparam logic SRC_D0 = 1'b0;
   localparam logic SRC_D1 = 1'b1;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: priority pointer register plus combinational grant.
// The pointer moves to the other source whenever 'advance' is pulsed.
module rr_grant2 (
   input  logic       clk,
   input  logic       nRst,
   input  logic       v0,
   input  logic       v1,
   input  logic       advance,
   input  logic       advSrc,
   output logic [1:0] grant
);

   logic pri_q;
   logic pri_d;

   always_comb begin
      pri_d = pri_q;
      if (advance) begin
         pri_d = ~advSrc;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         pri_q <= 1'b0;
      end else begin
         pri_q <= pri_d;
      end
   end

   // Contention goes to the pointer; a lone requester always wins.
   always_comb begin
      grant = 2'b00;
      if (v0 && v1) begin
         grant = pri_q ? 2'b10 : 2'b01;
      end else begin
         grant = {v1, v0};
      end
   end

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin 2:1 stream arbiter with a single registered output stage and sel.
// Define MUX2_ARB_LOCK_EN to add packet locking with last0/last1/outLast.
module mux2_stream_arbiter
   import mux2_stream_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic [WIDTH-1:0] d0,
   input  logic             v0,
   output logic             r0,
   input  logic [WIDTH-1:0] d1,
   input  logic             v1,
   output logic             r1,
`ifdef MUX2_ARB_LOCK_EN
   input  logic             last0,
   input  logic             last1,
   output logic             outLast,
`endif
   output logic [WIDTH-1:0] out,
   output logic             outValid,
   input  logic             outReady,
   output logic             sel
);

   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             sel_q, sel_d;

   logic       can_load;
   logic [1:0] grant;
   logic       gv0, gv1;
   logic       xfer0, xfer1, xfer;
   logic       xfer_src;
   logic       advance;

   assign can_load = !out_valid_q | outReady;

   // Readies are forced low while reset is asserted.
   assign r0 = nRst & can_load & grant[0];
   assign r1 = nRst & can_load & grant[1];

   assign xfer0    = v0 & r0;
   assign xfer1    = v1 & r1;
   assign xfer     = xfer0 | xfer1;
   assign xfer_src = xfer1 ? SRC_D1 : SRC_D0;

`ifdef MUX2_ARB_LOCK_EN
   arb_state_e state_q, state_d;
   logic       out_last_q, out_last_d;
   logic       xfer_last;

   assign xfer_last = xfer1 ? last1 : last0;
   assign gv0       = v0 & (state_q != LOCK1);
   assign gv1       = v1 & (state_q != LOCK0);
   // The pointer only moves at packet boundaries.
   assign advance   = xfer & xfer_last;
   assign outLast   = out_last_q;

   always_comb begin
      state_d    = state_q;
      out_last_d = out_last_q;
      if (xfer) begin
         out_last_d = xfer_last;
         if (xfer_last) begin
            state_d = ARB;
         end else begin
            state_d = (xfer_src == SRC_D1) ? LOCK1 : LOCK0;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= ARB;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_last_q <= out_last_d;
      end
   end
`else
   assign gv0     = v0;
   assign gv1     = v1;
   assign advance = xfer;
`endif

   rr_grant2 u_rr_grant2 (
      .clk     (clk),
      .nRst    (nRst),
      .v0      (gv0),
      .v1      (gv1),
      .advance (advance),
      .advSrc  (xfer_src),
      .grant   (grant)
   );

   always_comb begin
      out_d       = out_q;
      sel_d       = sel_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         out_d       = xfer1 ? d1 : d0;
         sel_d       = xfer_src;
         out_valid_d = 1'b1;
      end else if (outReady) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         out_q       <= '0;
         sel_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out      = out_q;
   assign sel      = sel_q;
   assign outValid = out_valid_q;

endmodule
